sat_narrow: RTL and testbench

Streaming signed narrower: converts M-bit two's-complement samples to N-bit with saturation instead of wrap. It is the inverse direction of the team's sign extender: extend M<-N, narrow N<-M. Valid/ready on both sides, a 2-entry skid buffer so o_ready is registered, and saturation statistics (per-sample flag, sticky flag, event counter). Sits at datapath width-reduction points, e.g. accumulator output to storage.

---
 rtl/sat_narrow_pkg.sv | 47 ++++
 rtl/sat_skid.sv | 91 +++++++++
 rtl/sat_narrow.sv | 102 ++++++++++
 tb/tb_sat_narrow.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sat_narrow_pkg.sv
// ============================================================================
//  Module : sat_narrow_pkg
//  Brief  : Shared types and helpers for the saturating signed narrower.
//           Provides the skid-buffer state encoding, the N-bit signed
//           clamp limits and the "sample fits in N bits" test.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sat_narrow_pkg;

  // Skid buffer occupancy; explicit 2-bit encoding
  typedef enum logic [1:0] {
    SK_EMPTY = 2'd0,
    SK_ONE   = 2'd1,
    SK_FULL  = 2'd2
  } skid_state_e;

  // Largest / smallest N-bit signed values, held in 32-bit containers
  typedef struct packed {
    logic [31:0] max_v;
    logic [31:0] min_v;
  } sat_lim_t;

  // max = 2^(n-1)-1, min = -2^(n-1) (bitwise complement of max)
  function automatic sat_lim_t sat_limits(input int n);
    sat_lim_t r;
    r.max_v = (32'd1 << (n - 1)) - 32'd1;
    r.min_v = ~r.max_v;
    return r;
  endfunction

  // A sample fits in n bits when bits [m-1:n-1] are all copies of the sign
  function automatic logic fits(input logic [63:0] x, input int m, input int n);
    logic ok;
    logic sgn;
    ok  = 1'b1;
    sgn = x[m - 1];
    for (int i = n - 1; i < m; i++) begin
      if (x[i[5:0]] != sgn) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_skid.sv
// ============================================================================
//  Module : sat_skid
//  Brief  : Generic 2-entry valid/ready skid buffer with a registered
//           o_ready. Strict FIFO order; the head entry drives o_data.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_skid
  import sat_narrow_pkg::*;
#(
  parameter int W = 5
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  skid_state_e  state_q, state_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         ready_q, ready_d;
  logic         w_acc;
  logic         w_xfer;

  assign w_acc  = i_valid && ready_q;
  assign w_xfer = (state_q != SK_EMPTY) && i_ready;

  // State and storage registers; reset discards all buffered entries
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= SK_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      ready_q <= ready_d;
    end
  end

  // Next-state and entry movement; FULL never sees an accept since ready is low
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      SK_EMPTY: begin
        if (w_acc) begin
          head_d  = i_data;
          state_d = SK_ONE;
        end
      end
      SK_ONE: begin
        if (w_acc && w_xfer) begin
          head_d = i_data;
        end else if (w_acc) begin
          tail_d  = i_data;
          state_d = SK_FULL;
        end else if (w_xfer) begin
          state_d = SK_EMPTY;
        end
      end
      SK_FULL: begin
        if (w_xfer) begin
          head_d  = tail_q;
          state_d = SK_ONE;
        end
      end
      default: state_d = SK_EMPTY;
    endcase
    ready_d = (state_d != SK_FULL);
  end

  // Outputs come straight from registers
  always_comb begin
    o_valid = (state_q != SK_EMPTY);
    o_data  = head_q;
    o_ready = ready_q;
  end

endmodule

`default_nettype wire

// File: rtl/sat_narrow.sv
// ============================================================================
//  Module : sat_narrow
//  Brief  : Streaming M->N bit signed narrower with saturation, skid-buffered
//           valid/ready handshake and saturation statistics (per-sample flag,
//           sticky flag, saturating event counter).
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_narrow
  import sat_narrow_pkg::*;
#(
  parameter int M     = 6,
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [M-1:0]     i_x,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [N-1:0]     o_y,
  output logic             o_sat,
  output logic             o_sat_sticky,
  input  logic             i_clr_sticky,
  output logic [CNT_W-1:0] o_sat_cnt
);

  generate
    if (!(M > N) || (N < 2) || (M > 64)) begin : g_bad_params
      $error("sat_narrow: requires 2 <= N < M <= 64");
    end
  endgenerate

  localparam sat_lim_t         c_lim     = sat_limits(N);
  localparam logic [N-1:0]     c_y_max   = c_lim.max_v[N-1:0];
  localparam logic [N-1:0]     c_y_min   = c_lim.min_v[N-1:0];
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [N-1:0]     w_y;
  logic             w_sat;
  logic             w_acc;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clamp to the N-bit signed range instead of wrapping
  always_comb begin
    w_y   = i_x[N-1:0];
    w_sat = 1'b0;
    if (!fits({{(64-M){1'b0}}, i_x}, M, N)) begin
      w_sat = 1'b1;
      w_y   = i_x[M-1] ? c_y_min : c_y_max;
    end
  end

  assign w_acc = i_valid && o_ready;

  // Stats move at accept time; a saturating accept beats a same-cycle clear
  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (w_acc && w_sat) begin
      sticky_d = 1'b1;
      if (cnt_q != c_cnt_max) cnt_d = cnt_q + c_cnt_one;
    end else if (i_clr_sticky) begin
      sticky_d = 1'b0;
    end
  end

  // Stats registers; only reset clears the counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_sat_sticky = sticky_q;
  assign o_sat_cnt    = cnt_q;

  sat_skid #(
    .W (N + 1)
  ) u_skid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  ({w_sat, w_y}),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  ({o_sat, o_y})
  );

endmodule

`default_nettype wire

// File: tb/tb_sat_narrow.sv
// ============================================================================
//  Module : tb_sat_narrow
//  Brief  : Directed self-checking bench for sat_narrow (M=6, N=4, CNT_W=8).
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sat_narrow;

  logic       clk;
  logic       rst;
  logic       valid_i;
  logic       ready_o;
  logic [5:0] x_i;
  logic       valid_o;
  logic       ready_i;
  logic [3:0] y_o;
  logic       sat_o;
  logic       sticky_o;
  logic       clr_i;
  logic [7:0] cnt_o;

  int errors = 0;
  int checks = 0;

  sat_narrow #(.M(6), .N(4), .CNT_W(8)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_valid      (valid_i),
    .o_ready      (ready_o),
    .i_x          (x_i),
    .o_valid      (valid_o),
    .i_ready      (ready_i),
    .o_y          (y_o),
    .o_sat        (sat_o),
    .o_sat_sticky (sticky_o),
    .i_clr_sticky (clr_i),
    .o_sat_cnt    (cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference clamp via signed range comparison
  function automatic logic [4:0] model(input logic [5:0] x);
    int v;
    v = $signed(x);
    if (v > 7)  return {1'b1, 4'b0111};
    if (v < -8) return {1'b1, 4'b1000};
    return {1'b0, x[3:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; valid_i = 1'b0; clr_i = 1'b0; ready_i = 1'b0; x_i = '0;
    step();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
    checks++; if (y_o !== 4'h0)     begin errors++; $display("FAIL reset_y got=%h exp=0", y_o); end
    checks++; if (sat_o !== 1'b0)   begin errors++; $display("FAIL reset_sat got=%b exp=0", sat_o); end
    checks++; if (sticky_o !== 1'b0) begin errors++; $display("FAIL reset_sticky got=%b exp=0", sticky_o); end
    checks++; if (cnt_o !== 8'd0)   begin errors++; $display("FAIL reset_cnt got=%0d exp=0", cnt_o); end
  endtask

  task automatic test_spot();
    logic [5:0] xs [4];
    logic [3:0] ys [4];
    logic       ss [4];
    xs = '{6'b000101, 6'b001000, 6'b110111, 6'b111000};
    ys = '{4'b0101,   4'b0111,   4'b1000,   4'b1000};
    ss = '{1'b0,      1'b1,      1'b1,      1'b0};
    do_reset();
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); valid_i = 1'b1; x_i = xs[i];
      step();
      checks++; if (y_o !== ys[i] || sat_o !== ss[i] || valid_o !== 1'b1) begin
        errors++; $display("FAIL spot_%0d got y=%b sat=%b v=%b exp y=%b sat=%b v=1", i, y_o, sat_o, valid_o, ys[i], ss[i]);
      end
    end
    @(negedge clk); valid_i = 1'b0;
  endtask

  task automatic test_sweep();
    logic [4:0] e;
    do_reset();
    ready_i = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk); valid_i = 1'b1; x_i = 6'(i);
      step();
      e = model(6'(i));
      checks++; if (valid_o !== 1'b1 || y_o !== e[3:0] || sat_o !== e[4]) begin
        errors++; $display("FAIL sweep_x%0d got v=%b y=%b sat=%b exp v=1 y=%b sat=%b", i, valid_o, y_o, sat_o, e[3:0], e[4]);
      end
    end
    @(negedge clk); valid_i = 1'b0;
    checks++; if (cnt_o !== 8'd48) begin errors++; $display("FAIL sweep_cnt got=%0d exp=48", cnt_o); end
    checks++; if (sticky_o !== 1'b1) begin errors++; $display("FAIL sweep_sticky got=%b exp=1", sticky_o); end
  endtask

  task automatic test_backpressure();
    do_reset();
    ready_i = 1'b0;
    @(negedge clk); valid_i = 1'b1; x_i = 6'd3;
    step();
    checks++; if (ready_o !== 1'b1 || valid_o !== 1'b1 || y_o !== 4'd3) begin
      errors++; $display("FAIL bp_first got rdy=%b v=%b y=%0d exp rdy=1 v=1 y=3", ready_o, valid_o, y_o);
    end
    @(negedge clk); x_i = 6'd4;
    step();
    checks++; if (ready_o !== 1'b0 || y_o !== 4'd3) begin
      errors++; $display("FAIL bp_full got rdy=%b y=%0d exp rdy=0 y=3", ready_o, y_o);
    end
    @(negedge clk); x_i = 6'd5;
    step();
    checks++; if (ready_o !== 1'b0 || y_o !== 4'd3 || valid_o !== 1'b1) begin
      errors++; $display("FAIL bp_hold got rdy=%b v=%b y=%0d exp rdy=0 v=1 y=3", ready_o, valid_o, y_o);
    end
    @(negedge clk); ready_i = 1'b1;
    step();
    checks++; if (ready_o !== 1'b1 || y_o !== 4'd4 || valid_o !== 1'b1) begin
      errors++; $display("FAIL bp_drain1 got rdy=%b v=%b y=%0d exp rdy=1 v=1 y=4", ready_o, valid_o, y_o);
    end
    step();
    checks++; if (y_o !== 4'd5 || valid_o !== 1'b1) begin
      errors++; $display("FAIL bp_drain2 got v=%b y=%0d exp v=1 y=5", valid_o, y_o);
    end
    @(negedge clk); valid_i = 1'b0;
    step();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL bp_empty got v=%b exp 0", valid_o); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] v;
    do_reset();
    ready_i = 1'b1;
    for (int i = 0; i < 11; i++) begin
      v = 6'(i - 5);
      @(negedge clk); valid_i = 1'b1; x_i = v;
      step();
      checks++; if (ready_o !== 1'b1 || valid_o !== 1'b1 || y_o !== v[3:0]) begin
        errors++; $display("FAIL b2b_%0d got rdy=%b v=%b y=%h exp rdy=1 v=1 y=%h", i, ready_o, valid_o, y_o, v[3:0]);
      end
    end
    @(negedge clk); valid_i = 1'b0;
  endtask

  task automatic test_sticky();
    do_reset();
    ready_i = 1'b1;
    @(negedge clk); valid_i = 1'b1; x_i = 6'b001000;
    step();
    checks++; if (sticky_o !== 1'b1 || cnt_o !== 8'd1) begin
      errors++; $display("FAIL sticky_set got s=%b c=%0d exp s=1 c=1", sticky_o, cnt_o);
    end
    @(negedge clk); valid_i = 1'b0; clr_i = 1'b1;
    step();
    checks++; if (sticky_o !== 1'b0 || cnt_o !== 8'd1) begin
      errors++; $display("FAIL sticky_clr got s=%b c=%0d exp s=0 c=1", sticky_o, cnt_o);
    end
    @(negedge clk); valid_i = 1'b1; x_i = 6'b100000; clr_i = 1'b1;
    step();
    checks++; if (sticky_o !== 1'b1 || cnt_o !== 8'd2 || y_o !== 4'b1000 || sat_o !== 1'b1) begin
      errors++; $display("FAIL sticky_setwins got s=%b c=%0d y=%b sat=%b exp s=1 c=2 y=1000 sat=1", sticky_o, cnt_o, y_o, sat_o);
    end
    @(negedge clk); valid_i = 1'b0; clr_i = 1'b0;
  endtask

  task automatic test_cnt_sat();
    do_reset();
    ready_i = 1'b1;
    @(negedge clk); valid_i = 1'b1; x_i = 6'b100000;
    for (int i = 0; i < 254; i++) step();
    checks++; if (cnt_o !== 8'd254) begin errors++; $display("FAIL cnt_254 got=%0d exp=254", cnt_o); end
    for (int i = 0; i < 46; i++) step();
    checks++; if (cnt_o !== 8'd255) begin errors++; $display("FAIL cnt_300 got=%0d exp=255", cnt_o); end
    for (int i = 0; i < 5; i++) step();
    checks++; if (cnt_o !== 8'd255) begin errors++; $display("FAIL cnt_hold got=%0d exp=255", cnt_o); end
    @(negedge clk); valid_i = 1'b0;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    ready_i = 1'b0;
    @(negedge clk); valid_i = 1'b1; x_i = 6'b011111;
    step();
    @(negedge clk); x_i = 6'b000001;
    step();
    checks++; if (ready_o !== 1'b0 || cnt_o !== 8'd1) begin
      errors++; $display("FAIL mid_full got rdy=%b c=%0d exp rdy=0 c=1", ready_o, cnt_o);
    end
    @(negedge clk); rst = 1'b1; x_i = 6'b000010;
    step();
    checks++; if (valid_o !== 1'b0 || ready_o !== 1'b1 || cnt_o !== 8'd0 || sticky_o !== 1'b0) begin
      errors++; $display("FAIL mid_reset got v=%b rdy=%b c=%0d s=%b exp v=0 rdy=1 c=0 s=0", valid_o, ready_o, cnt_o, sticky_o);
    end
    @(negedge clk); rst = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    step(); step();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL mid_noghost got v=%b y=%h exp v=0", valid_o, y_o); end
    @(negedge clk); valid_i = 1'b1; x_i = 6'd6;
    step();
    checks++; if (valid_o !== 1'b1 || y_o !== 4'd6) begin
      errors++; $display("FAIL mid_resume got v=%b y=%0d exp v=1 y=6", valid_o, y_o);
    end
    @(negedge clk); valid_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; x_i = '0; ready_i = 1'b0; clr_i = 1'b0;
    test_reset();
    test_spot();
    test_sweep();
    test_backpressure();
    test_back_to_back();
    test_sticky();
    test_cnt_sat();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
